async_fifo_gray: RTL

//  Next-generation clock-domain-crossing FIFO between producer (PROD_CLK) and consumer (CON_CLK).

---
 rtl/async_fifo_gray.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/async_fifo_gray.sv
// async_fifo_gray
//   Clock-domain-crossing FIFO between a producer on PROD_CLK and a consumer
//   on CON_CLK. Pointers are kept in binary and Gray form. Only the Gray form
//   crosses domains, through P_SYNC_STAGES flops. Depth is 2**P_ADDR_WIDTH.
//   Each side can transfer one word per clock.
//   All flags and levels are registered. They are computed from the
//   post-update local pointer and the synchronised far-side pointer, so they
//   can only ever be pessimistic.
// Ports
//   PROD_CLK, CON_CLK            write / read domain clocks
//   RST_n                        async active-low reset; release is synchronised per domain
//   W_EN, DATA_IN                write request and data (PROD_CLK)
//   FULL, ALMOST_FULL, WR_LEVEL  writer-side status (PROD_CLK)
//   OVERFLOW                     one-cycle pulse: write attempted while FULL
//   R_EN                         read request (CON_CLK)
//   DATA_OUT, RD_VALID           registered read data, and a strobe marking a fresh pop
//   EMPTY, ALMOST_EMPTY, RD_LEVEL reader-side status (CON_CLK)
//   UNDERFLOW                    one-cycle pulse: read attempted while EMPTY
`timescale 1ns/1ps
module async_fifo_gray #(
    parameter int P_DATA_WIDTH    = 8,
    parameter int P_ADDR_WIDTH    = 4,
    parameter int P_SYNC_STAGES   = 2,
    parameter int P_AFULL_THRESH  = 12,
    parameter int P_AEMPTY_THRESH = 2
) (
    input  logic                    PROD_CLK,
    input  logic                    CON_CLK,
    input  logic                    RST_n,
    input  logic                    W_EN,
    input  logic [P_DATA_WIDTH-1:0] DATA_IN,
    output logic                    FULL,
    output logic                    ALMOST_FULL,
    output logic [P_ADDR_WIDTH:0]   WR_LEVEL,
    output logic                    OVERFLOW,
    input  logic                    R_EN,
    output logic [P_DATA_WIDTH-1:0] DATA_OUT,
    output logic                    RD_VALID,
    output logic                    EMPTY,
    output logic                    ALMOST_EMPTY,
    output logic [P_ADDR_WIDTH:0]   RD_LEVEL,
    output logic                    UNDERFLOW
);
    localparam int A     = P_ADDR_WIDTH;
    localparam int DEPTH = 1 << A;
    localparam int LAST  = P_SYNC_STAGES - 1;

    typedef logic [A:0] ptr_t;

    // Full when the write pointer equals the read pointer with the top two Gray bits inverted.
    localparam ptr_t C_FULL_MASK = ptr_t'(3) << (A - 1);
    localparam ptr_t C_AFULL     = ptr_t'(P_AFULL_THRESH);
    localparam ptr_t C_AEMPTY    = ptr_t'(P_AEMPTY_THRESH);

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[A] = g[A];
        for (int i = A - 1; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

    logic [1:0] wr_rst_sync_q, rd_rst_sync_q;
    logic       wr_rst_n_s, rd_rst_n_s;

    logic [P_DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write-domain state
    ptr_t wbin_q, wgray_q, wbin_d, wgray_d, rbin_sync_s, wr_level_q, wr_level_d;
    ptr_t rsync_q [P_SYNC_STAGES];
    logic wr_fire_s, full_q, full_d, afull_q, afull_d, overflow_q, overflow_d;

    // Read-domain state
    ptr_t rbin_q, rgray_q, rbin_d, rgray_d, wbin_sync_s, rd_level_q, rd_level_d;
    ptr_t wsync_q [P_SYNC_STAGES];
    logic rd_fire_s, empty_q, empty_d, aempty_q, aempty_d, underflow_q, underflow_d;
    logic rd_valid_q, rd_valid_d;
    logic [P_DATA_WIDTH-1:0] data_out_q, data_out_d;

    // Reset release synchroniser, write domain (assertion stays asynchronous)
    always_ff @(posedge PROD_CLK or negedge RST_n) begin
        if (!RST_n) wr_rst_sync_q <= 2'b00;
        else        wr_rst_sync_q <= {wr_rst_sync_q[0], 1'b1};
    end

    // Reset release synchroniser, read domain
    always_ff @(posedge CON_CLK or negedge RST_n) begin
        if (!RST_n) rd_rst_sync_q <= 2'b00;
        else        rd_rst_sync_q <= {rd_rst_sync_q[0], 1'b1};
    end

    assign wr_rst_n_s = wr_rst_sync_q[1];
    assign rd_rst_n_s = rd_rst_sync_q[1];

    // Storage array, written only on an accepted write; contents are not reset
    always_ff @(posedge PROD_CLK) begin
        if (wr_fire_s) mem_q[wbin_q[A-1:0]] <= DATA_IN;
    end

    // Write-side next state: pointer advance, flags and level from the post-update pointer
    always_comb begin
        wr_fire_s   = W_EN & ~full_q;
        wbin_d      = wbin_q + ptr_t'(wr_fire_s);
        wgray_d     = bin2gray(wbin_d);
        rbin_sync_s = gray2bin(rsync_q[LAST]);
        wr_level_d  = wbin_d - rbin_sync_s;
        full_d      = (wgray_d == (rsync_q[LAST] ^ C_FULL_MASK));
        afull_d     = (wr_level_d >= C_AFULL);
        overflow_d  = W_EN & full_q;
    end

    // Write-side registers, including the read-pointer synchroniser chain
    always_ff @(posedge PROD_CLK or negedge wr_rst_n_s) begin
        if (!wr_rst_n_s) begin
            wbin_q     <= '0;
            wgray_q    <= '0;
            wr_level_q <= '0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            overflow_q <= 1'b0;
            for (int i = 0; i < P_SYNC_STAGES; i++) rsync_q[i] <= '0;
        end else begin
            wbin_q     <= wbin_d;
            wgray_q    <= wgray_d;
            wr_level_q <= wr_level_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            overflow_q <= overflow_d;
            rsync_q[0] <= rgray_q;
            for (int i = 1; i < P_SYNC_STAGES; i++) rsync_q[i] <= rsync_q[i - 1];
        end
    end

    // Read-side next state: pop, data capture, flags and level from the post-update pointer
    always_comb begin
        rd_fire_s   = R_EN & ~empty_q;
        rbin_d      = rbin_q + ptr_t'(rd_fire_s);
        rgray_d     = bin2gray(rbin_d);
        wbin_sync_s = gray2bin(wsync_q[LAST]);
        rd_level_d  = wbin_sync_s - rbin_d;
        empty_d     = (rgray_d == wsync_q[LAST]);
        aempty_d    = (rd_level_d <= C_AEMPTY);
        underflow_d = R_EN & empty_q;
        rd_valid_d  = rd_fire_s;
        if (rd_fire_s) data_out_d = mem_q[rbin_q[A-1:0]];
        else           data_out_d = data_out_q;
    end

    // Read-side registers, including the write-pointer synchroniser chain
    always_ff @(posedge CON_CLK or negedge rd_rst_n_s) begin
        if (!rd_rst_n_s) begin
            rbin_q      <= '0;
            rgray_q     <= '0;
            rd_level_q  <= '0;
            empty_q     <= 1'b1;
            aempty_q    <= 1'b1;
            underflow_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            data_out_q  <= '0;
            for (int i = 0; i < P_SYNC_STAGES; i++) wsync_q[i] <= '0;
        end else begin
            rbin_q      <= rbin_d;
            rgray_q     <= rgray_d;
            rd_level_q  <= rd_level_d;
            empty_q     <= empty_d;
            aempty_q    <= aempty_d;
            underflow_q <= underflow_d;
            rd_valid_q  <= rd_valid_d;
            data_out_q  <= data_out_d;
            wsync_q[0]  <= wgray_q;
            for (int i = 1; i < P_SYNC_STAGES; i++) wsync_q[i] <= wsync_q[i - 1];
        end
    end

    assign FULL         = full_q;
    assign ALMOST_FULL  = afull_q;
    assign WR_LEVEL     = wr_level_q;
    assign OVERFLOW     = overflow_q;
    assign DATA_OUT     = data_out_q;
    assign RD_VALID     = rd_valid_q;
    assign EMPTY        = empty_q;
    assign ALMOST_EMPTY = aempty_q;
    assign RD_LEVEL     = rd_level_q;
    assign UNDERFLOW    = underflow_q;

endmodule
